// File: rtl/program_loader.sv
// program_loader: streams a program into the instruction memory write port,
// pads the remaining addresses with FILL_VALUE, then releases the CPU.
module program_loader #(
  parameter int                 DEPTH      = 16,
  parameter int                 ADDR_W     = 4,
  parameter int                 DATA_W     = 8,
  parameter logic [DATA_W-1:0]  FILL_VALUE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_last,
  output logic              src_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   loaded_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_ptr;

  // Loader FSM with registered memory write port and status outputs.
  // done/error are set from inside DONE/ERR, so they rise one cycle after the
  // final write strobe and never overlap mem_we.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      src_ready    <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_we       <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      loaded_count <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_LOAD;
            src_ready    <= 1'b1;
            wr_ptr       <= '0;
            loaded_count <= '0;
          end
        end

        S_LOAD: begin
          if (src_valid && src_ready) begin
            mem_we       <= 1'b1;
            mem_addr     <= wr_ptr;
            mem_data     <= src_data;
            wr_ptr       <= wr_ptr + ADDR_W'(1);
            loaded_count <= loaded_count + (ADDR_W+1)'(1);
            if (src_last) begin
              src_ready <= 1'b0;
              state     <= (wr_ptr == LAST_ADDR) ? S_DONE : S_FILL;
            end else if (wr_ptr == LAST_ADDR) begin
              src_ready <= 1'b0;
              state     <= S_ERR;
            end
          end
        end

        S_FILL: begin
          mem_we   <= 1'b1;
          mem_addr <= wr_ptr;
          mem_data <= FILL_VALUE;
          wr_ptr   <= wr_ptr + ADDR_W'(1);
          if (wr_ptr == LAST_ADDR) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          if (start) begin
            state        <= S_LOAD;
            src_ready    <= 1'b1;
            wr_ptr       <= '0;
            loaded_count <= '0;
            done         <= 1'b0;
            cpu_hold     <= 1'b1;
          end else begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end

        S_ERR: begin
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          if (start) begin
            state        <= S_LOAD;
            src_ready    <= 1'b1;
            wr_ptr       <= '0;
            loaded_count <= '0;
            error        <= 1'b0;
          end else begin
            error <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader with a write log of the memory port.
module tb_program_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_last;
  logic       src_ready;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_we;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [4:0] loaded_count;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  logic [3:0] wa [$];
  logic [7:0] wd [$];
  logic [7:0] prog [16];

  program_loader #(
    .DEPTH(16),
    .ADDR_W(4),
    .DATA_W(8),
    .FILL_VALUE(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_last(src_last),
    .src_ready(src_ready),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_we(mem_we),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .loaded_count(loaded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-memory side: log every write strobe and any done/we overlap.
  always @(posedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
      if (done) overlap++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  // Present one byte and hold it until the edge that accepts it.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    src_valid = 1'b1;
    src_data  = d;
    src_last  = l;
    while (!src_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send ready", src_ready, 1);
    tick();
  endtask

  task automatic idle_src();
    src_valid = 1'b0;
    src_data  = 8'h00;
    src_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for done; checks the tick count and that the previous cycle wrote addr 15.
  task automatic wait_done(input string tag, input int exp_ticks);
    int n;
    logic pwe;
    logic [3:0] pa;
    n = 0;
    pwe = mem_we;
    pa = mem_addr;
    while (!done && n < 100) begin
      pwe = mem_we;
      pa = mem_addr;
      tick();
      n++;
    end
    chk($sformatf("%s done latency", tag), n, exp_ticks);
    chk($sformatf("%s done after addr15 write", tag), {pwe, pa}, {1'b1, 4'hF});
    chk($sformatf("%s cpu_hold", tag), cpu_hold, 0);
    chk($sformatf("%s error", tag), error, 0);
  endtask

  task automatic check_log(input string tag, input int plen);
    chk($sformatf("%s write count", tag), wa.size(), 16);
    for (int i = 0; i < wa.size() && i < 16; i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), wa[i], i);
      chk($sformatf("%s data[%0d]", tag, i), wd[i], (i < plen) ? prog[i] : 8'h00);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    idle_src();
    tick();
    tick();

    // Reset values
    chk("rst src_ready", src_ready, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_data", mem_data, 0);
    chk("rst cpu_hold", cpu_hold, 1);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst loaded_count", loaded_count, 0);
    rst_n = 1'b1;
    tick();
    chk("idle src_ready", src_ready, 0);

    // Short program A1/B2/C3 then fill
    clear_log();
    do_start();
    chk("t1 src_ready after start", src_ready, 1);
    prog[0] = 8'hA1; prog[1] = 8'hB2; prog[2] = 8'hC3;
    send(8'hA1, 1'b0);
    chk("t1 first write we", mem_we, 1);
    chk("t1 first write addr", mem_addr, 0);
    chk("t1 first write data", mem_data, 8'hA1);
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b1);
    idle_src();
    chk("t1 src_ready after last", src_ready, 0);
    wait_done("t1", 14);
    chk("t1 loaded_count", loaded_count, 3);
    check_log("t1", 3);

    // Exactly 16 bytes, no fill
    clear_log();
    do_start();
    chk("t2 done cleared", done, 0);
    chk("t2 cpu_hold", cpu_hold, 1);
    for (int i = 0; i < 16; i++) begin
      prog[i] = 8'h10 + 8'(i);
      send(prog[i], i == 15);
    end
    idle_src();
    wait_done("t2", 1);
    chk("t2 loaded_count", loaded_count, 16);
    check_log("t2", 16);

    // Overflow: 16 bytes without last
    clear_log();
    do_start();
    for (int i = 0; i < 16; i++) begin
      prog[i] = 8'h40 + 8'(i);
      send(prog[i], 1'b0);
    end
    idle_src();
    chk("t3 overflow write addr", {mem_we, mem_addr}, {1'b1, 4'hF});
    chk("t3 error not yet", error, 0);
    tick();
    chk("t3 error", error, 1);
    chk("t3 done", done, 0);
    chk("t3 cpu_hold", cpu_hold, 1);
    chk("t3 src_ready", src_ready, 0);
    chk("t3 loaded_count", loaded_count, 16);
    tick();
    tick();
    chk("t3 error sticky", error, 1);
    check_log("t3", 16);
    do_start();
    chk("t3 error cleared", error, 0);
    chk("t3 src_ready restart", src_ready, 1);
    chk("t3 loaded_count cleared", loaded_count, 0);

    // Toggling src_valid with garbage on idle cycles
    clear_log();
    prog[0] = 8'h5A; prog[1] = 8'h6B; prog[2] = 8'h7C; prog[3] = 8'h8D;
    for (int i = 0; i < 4; i++) begin
      src_valid = 1'b1;
      src_data  = prog[i];
      src_last  = (i == 3);
      tick();
      src_valid = 1'b0;
      src_data  = 8'hEE;
      src_last  = 1'b1;
      tick();
    end
    idle_src();
    wait_done("t4", 12);
    chk("t4 loaded_count", loaded_count, 4);
    check_log("t4", 4);

    // Reset after 5 accepted bytes
    clear_log();
    do_start();
    for (int i = 0; i < 5; i++) send(8'h90 + 8'(i), 1'b0);
    chk("t5 fifth write addr", {mem_we, mem_addr}, {1'b1, 4'h4});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5 mem_we", mem_we, 0);
    chk("t5 cpu_hold", cpu_hold, 1);
    chk("t5 done", done, 0);
    chk("t5 loaded_count", loaded_count, 0);
    chk("t5 src_ready", src_ready, 0);
    for (int i = 0; i < 8; i++) tick();
    idle_src();
    chk("t5 write count", wa.size(), 5);
    chk("t5 still held", cpu_hold, 1);

    // One-byte program, then reload from DONE with start pulsed during fill
    do_start();
    prog[0] = 8'h33;
    send(8'h33, 1'b1);
    idle_src();
    wait_done("t6a", 16);
    clear_log();
    do_start();
    prog[0] = 8'hFF;
    send(8'hFF, 1'b1);
    idle_src();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6 start ignored in fill", src_ready, 0);
    tick();
    tick();
    wait_done("t6", 13);
    chk("t6 loaded_count", loaded_count, 1);
    check_log("t6", 1);
    tick();
    chk("t6 done stays", done, 1);

    chk("done/we overlap count", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Sequential writer for the 16 x 8 instruction memory. It accepts a program as a byte stream over a valid/ready handshake and writes each byte to consecutive memory addresses starting at 0. It then pads the unused addresses with a fill value and releases the CPU. It sits between the host/boot source and the instruction memory's write port (address, write data), and holds the CPU's program counter until the load completes.

## Interface
- DEPTH, 16, number of instruction memory entries.
- ADDR_W, 4, memory address width (log2 DEPTH).
- DATA_W, 8, instruction width.
- FILL_VALUE, 8'h00, value written to addresses after the last program byte (NOP).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, active-low, synchronous.
- start  input  1  begin a load; sampled in IDLE, DONE and ERR only.
- src_valid  input  1  src_data/src_last are valid this cycle.
- src_data  input  DATA_W  program byte.
- src_last  input  1  marks the final program byte.
- src_ready  output  1  loader can accept a byte this cycle.
- mem_addr  output  ADDR_W  write address to instruction memory.
- mem_data  output  DATA_W  write data to instruction memory.
- mem_we  output  1  one-cycle write strobe; mem_addr/mem_data are valid while high.
- cpu_hold  output  1  holds the CPU program counter at 0 while high.
- done  output  1  load complete; memory contents valid.
- error  output  1  program exceeded DEPTH bytes.
- loaded_count  output  ADDR_W+1  number of program bytes accepted in the last load (0..DEPTH).

## Operation
- Reset values: state IDLE, src_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, done=0, error=0, loaded_count=0. Reset does not clear memory contents.
- All outputs are registered. src_ready is 1 only in LOAD.
- IDLE: when start=1, go to LOAD; clear the internal write pointer and loaded_count.
- LOAD: a byte is accepted when src_valid=1 and src_ready=1. The accepted byte is written to the write pointer address, then the write pointer and loaded_count increment.
  - Accept with src_last=1 and pointer < DEPTH-1: go to FILL.
  - Accept with src_last=1 and pointer = DEPTH-1: go to DONE (no fill).
  - Accept with src_last=0 and pointer = DEPTH-1: the byte is still written; go to ERR.
- FILL: src_ready=0. Write FILL_VALUE once per cycle to each remaining address up to DEPTH-1, then go to DONE.
- DONE: done=1, cpu_hold=0. loaded_count holds its value. start=1 starts a reload: go to LOAD, done=0, cpu_hold=1, pointer=0, loaded_count=0.
- ERR: error=1, cpu_hold=1, done=0. Exit only via start=1 (to LOAD, error cleared) or reset.
- start is ignored in LOAD and FILL.
- src_data/src_last are ignored when src_valid=0.
- Write-pointer wrap is impossible: ERR or DONE is always entered at DEPTH-1.

## Timing
- Byte accepted on edge N: mem_we=1 with its mem_addr/mem_data during cycle N+1.
- Throughput: 1 byte/cycle while src_valid stays high.
- Last byte accepted at address k on edge N: fill writes k+1..DEPTH-1 during cycles N+2 .. N+DEPTH-k.
- done rises, and cpu_hold falls, in the cycle after the final mem_we cycle. Therefore done=1 never overlaps mem_we=1.
- start sampled on edge N: src_ready=1 from cycle N+1.
- Reset asserted mid-load or mid-fill: on the next edge all outputs take their reset values; no further writes occur.
- error asserts in the cycle after the overflow byte's write cycle.

## Test plan
- Reset, then start; stream 3 bytes 8'hA1, 8'hB2, 8'hC3 (last on the third) -> writes addr 0..2 with A1/B2/C3, then addr 3..15 with 8'h00. done=1 and cpu_hold=0 one cycle after the addr-15 write. loaded_count=3.
- Stream exactly 16 bytes 8'h10..8'h1F, last on the 16th -> 16 writes, no fill. done=1 the cycle after the addr-15 write. loaded_count=16.
- Stream 16 bytes with src_last never set -> all 16 written; error=1, done=0, cpu_hold=1. Then start -> error=0, src_ready=1.
- Toggle src_valid 1/0 every cycle with a 4-byte program -> exactly 4 program writes at addr 0..3, no duplicated or skipped addresses.
- Assert rst_n=0 for one cycle after 5 bytes accepted -> mem_we=0, cpu_hold=1, done=0, loaded_count=0 the next cycle; no further writes.
- From DONE, start and load 1 byte 8'hFF -> addr 0=FF, addr 1..15=00; loaded_count=1. start pulsed during FILL -> no effect.
